// File: rtl/touch_pkg.sv
// Shared timing defaults and counter sizing helper for the touch pad bank.
package touch_pkg;

  localparam int unsigned CLK_HZ       = 48_000_000;
  localparam int unsigned DEBOUNCE_1MS = CLK_HZ / 1000;
  localparam int unsigned LONG_1S      = CLK_HZ;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/touch_pad_chan.sv
// One touch pad channel: synchroniser, debounce, edge pulses and long-press timer.
module touch_pad_chan
  import touch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_1MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_sense_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o,
  output logic long_held_o
);

  localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_raw;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_pulse_q, long_pulse_d;
  logic                   long_held_q, long_held_d;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], pad_sense_n_i};
    sync_raw     = ~sync_q[SYNC_STAGES-1];
    deb_cnt_d    = deb_cnt_q;
    pressed_d    = pressed_q;
    hold_cnt_d   = hold_cnt_q;
    long_held_d  = long_held_q;
    long_pulse_d = 1'b0;

    // A disagreement must persist DEBOUNCE_CYCLES in a row to be accepted.
    if (sync_raw == pressed_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      pressed_d = sync_raw;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    press_d   = pressed_d & ~pressed_q;
    release_d = ~pressed_d & pressed_q;

    // Clearing on the next pressed level lets long_held drop with release_pulse.
    if (!pressed_d) begin
      hold_cnt_d  = '0;
      long_held_d = 1'b0;
    end else if (pressed_q && !long_held_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        long_pulse_d = 1'b1;
        long_held_d  = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '1;
      deb_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      pressed_q    <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_pulse_q <= 1'b0;
      long_held_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      deb_cnt_q    <= deb_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      pressed_q    <= pressed_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_pulse_q <= long_pulse_d;
      long_held_q  <= long_held_d;
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_pulse_q;
  assign long_held_o     = long_held_q;

endmodule

// File: rtl/touch_pad_bank.sv
// Bank of NUM_PADS touch pads with a registered count of pads currently held.
module touch_pad_bank
  import touch_pkg::*;
#(
  parameter int unsigned NUM_PADS          = 2,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_1MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S,
  localparam int unsigned CNT_W            = cnt_width(NUM_PADS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PADS-1:0] pad_sense_n_i,
  output logic [NUM_PADS-1:0] pad_return_o,
  output logic [NUM_PADS-1:0] pressed_o,
  output logic [NUM_PADS-1:0] press_pulse_o,
  output logic [NUM_PADS-1:0] release_pulse_o,
  output logic [NUM_PADS-1:0] long_pulse_o,
  output logic [NUM_PADS-1:0] long_held_o,
  output logic [CNT_W-1:0]    pressed_count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_chan
    touch_pad_chan #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .pad_sense_n_i  (pad_sense_n_i[g]),
      .pressed_o      (pressed_o[g]),
      .press_pulse_o  (press_pulse_o[g]),
      .release_pulse_o(release_pulse_o[g]),
      .long_pulse_o   (long_pulse_o[g]),
      .long_held_o    (long_held_o[g])
    );
  end

  // Popcount of the debounced levels; for two pads this is a half adder.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      count_d = count_d + CNT_W'(pressed_o[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pressed_count_o = count_q;
  assign pad_return_o    = '0;

endmodule
